multicycle_sequencer: RTL and testbench

- Parametrised multi-cycle sequencer for the SIWO core.
- It replaces single-cycle PC advance with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine.
- It owns the PC, the instruction register, retire/cycle counters, wait-state handshakes to instruction and data memory, and branch/jump resolution (absolute or PC-relative).
- The decoder, register file and ALU remain external; their decoded control lines feed this block.

---
 rtl/multicycle_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the SIWO core.
// Owns PC, instruction register, retire/cycle counters and memory wait-state handshakes.
module multicycle_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int INSN_WIDTH  = 9,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   _CLK,
    input  logic                   _reset,
    input  logic                   _start,
    input  logic [INSN_WIDTH-1:0]  _insnIn,
    input  logic                   _insnValid,
    input  logic                   _halt,
    input  logic                   _memAccess,
    input  logic                   _regWrite,
    input  logic                   _branchJump,
    input  logic                   _relative,
    input  logic [PC_WIDTH-1:0]    _destBranchJump,
    input  logic                   _memReady,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   insnFetch,
    output logic [INSN_WIDTH-1:0]  instruction,
    output logic                   memEnable,
    output logic                   regWriteEn,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] insnCount,
    output logic [COUNT_WIDTH-1:0] cycleCount
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] EXECUTE   = 3'd3;
    localparam logic [2:0] MEMORY    = 3'd4;
    localparam logic [2:0] WRITEBACK = 3'd5;
    localparam logic [2:0] HALTED    = 3'd6;

    logic [2:0]             state_r;
    logic [2:0]             stateNext_s;
    logic [PC_WIDTH-1:0]    pc_r;
    logic [PC_WIDTH-1:0]    pcRetire_s;
    logic [INSN_WIDTH-1:0]  ir_r;
    logic [COUNT_WIDTH-1:0] insnCount_r;
    logic [COUNT_WIDTH-1:0] cycleCount_r;
    logic                   insnFetch_r;
    logic                   memEnable_r;
    logic                   regWriteEn_r;
    logic                   halted_r;
    logic                   active_s;
    logic                   abort_s;
    logic                   launch_s;
    logic                   retire_s;
    logic                   irLoad_s;

    // Next-state selection; a dropped run level overrides every other transition
    always_comb begin
        stateNext_s = IDLE;
        launch_s    = 1'b0;
        retire_s    = 1'b0;
        irLoad_s    = 1'b0;
        active_s    = (state_r >= FETCH) && (state_r <= WRITEBACK);
        abort_s     = active_s && !_start;
        if (abort_s) begin
            stateNext_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (_start) begin
                        stateNext_s = FETCH;
                        launch_s    = 1'b1;
                    end else begin
                        stateNext_s = IDLE;
                    end
                end
                FETCH: begin
                    if (_insnValid) begin
                        stateNext_s = DECODE;
                        irLoad_s    = 1'b1;
                    end else begin
                        stateNext_s = FETCH;
                    end
                end
                DECODE: begin
                    if (_halt) begin
                        stateNext_s = HALTED;
                    end else begin
                        stateNext_s = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (_memAccess) begin
                        stateNext_s = MEMORY;
                    end else if (_regWrite) begin
                        stateNext_s = WRITEBACK;
                    end else begin
                        stateNext_s = FETCH;
                        retire_s    = 1'b1;
                    end
                end
                MEMORY: begin
                    if (!_memReady) begin
                        stateNext_s = MEMORY;
                    end else if (_regWrite) begin
                        stateNext_s = WRITEBACK;
                    end else begin
                        stateNext_s = FETCH;
                        retire_s    = 1'b1;
                    end
                end
                WRITEBACK: begin
                    stateNext_s = FETCH;
                    retire_s    = 1'b1;
                end
                HALTED: begin
                    if (_start) begin
                        stateNext_s = HALTED;
                    end else begin
                        stateNext_s = IDLE;
                    end
                end
                default: stateNext_s = IDLE;
            endcase
        end
    end

    // Retire target; the offset is as wide as the PC, so modulo addition is the sign-extended add
    always_comb begin
        if (!_branchJump) begin
            pcRetire_s = pc_r + PC_WIDTH'(1);
        end else if (_relative) begin
            pcRetire_s = pc_r + _destBranchJump;
        end else begin
            pcRetire_s = _destBranchJump;
        end
    end

    // State, PC, IR, counters and Moore strobes registered from the next state
    always_ff @(posedge _CLK or posedge _reset) begin
        if (_reset) begin
            state_r      <= IDLE;
            pc_r         <= {PC_WIDTH{1'b0}};
            ir_r         <= {INSN_WIDTH{1'b0}};
            insnCount_r  <= {COUNT_WIDTH{1'b0}};
            cycleCount_r <= {COUNT_WIDTH{1'b0}};
            insnFetch_r  <= 1'b0;
            memEnable_r  <= 1'b0;
            regWriteEn_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            insnFetch_r  <= (stateNext_s == FETCH);
            memEnable_r  <= (stateNext_s == MEMORY);
            regWriteEn_r <= (stateNext_s == WRITEBACK);
            halted_r     <= (stateNext_s == HALTED);
            if (irLoad_s) begin
                ir_r <= _insnIn;
            end
            if (abort_s) begin
                pc_r <= {PC_WIDTH{1'b0}};
            end else if (launch_s) begin
                pc_r         <= {PC_WIDTH{1'b0}};
                insnCount_r  <= {COUNT_WIDTH{1'b0}};
                cycleCount_r <= {COUNT_WIDTH{1'b0}};
            end else begin
                if (retire_s) begin
                    pc_r        <= pcRetire_s;
                    insnCount_r <= insnCount_r + COUNT_WIDTH'(1);
                end
                if (active_s && (cycleCount_r != {COUNT_WIDTH{1'b1}})) begin
                    cycleCount_r <= cycleCount_r + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign pc          = pc_r;
    assign instruction = ir_r;
    assign state       = state_r;
    assign insnCount   = insnCount_r;
    assign cycleCount  = cycleCount_r;
    assign insnFetch   = insnFetch_r;
    assign memEnable   = memEnable_r;
    assign regWriteEn  = regWriteEn_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction phase-list model.
module tb_multicycle_sequencer;

    localparam int PW   = 10;
    localparam int IW   = 9;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
    localparam int S_MEM = 4, S_WB = 5, S_HALT = 6;

    logic          clk = 1'b0;
    logic          reset, start, insnValid, halt, memAccess, regWrite;
    logic          branchJump, relative, memReady;
    logic [IW-1:0] insnIn;
    logic [PW-1:0] destBranchJump;
    logic [PW-1:0] pc;
    logic          insnFetch, memEnable, regWriteEn, halted;
    logic [IW-1:0] instruction;
    logic [2:0]    state;
    logic [CW-1:0] insnCount, cycleCount;

    int checks = 0;
    int errors = 0;
    int mState, mPc, mIr, mInsn, mCyc;

    multicycle_sequencer #(.PC_WIDTH(PW), .INSN_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
        ._CLK(clk), ._reset(reset), ._start(start), ._insnIn(insnIn),
        ._insnValid(insnValid), ._halt(halt), ._memAccess(memAccess),
        ._regWrite(regWrite), ._branchJump(branchJump), ._relative(relative),
        ._destBranchJump(destBranchJump), ._memReady(memReady),
        .pc(pc), .insnFetch(insnFetch), .instruction(instruction),
        .memEnable(memEnable), .regWriteEn(regWriteEn), .halted(halted),
        .state(state), .insnCount(insnCount), .cycleCount(cycleCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "/state"}, 32'(state), mState);
        chk({tag, "/insnFetch"}, 32'(insnFetch), 32'(mState == S_FETCH));
        chk({tag, "/memEnable"}, 32'(memEnable), 32'(mState == S_MEM));
        chk({tag, "/regWriteEn"}, 32'(regWriteEn), 32'(mState == S_WB));
        chk({tag, "/halted"}, 32'(halted), 32'(mState == S_HALT));
        chk({tag, "/pc"}, 32'(pc), mPc);
        chk({tag, "/instruction"}, 32'(instruction), mIr);
        chk({tag, "/insnCount"}, 32'(insnCount), mInsn);
        chk({tag, "/cycleCount"}, 32'(cycleCount), mCyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE: counters and PC clear, fetching begins
    task automatic restart();
        start = 1'b1;
        tick();
        mPc = 0; mInsn = 0; mCyc = 0; mState = S_FETCH;
        checkAll("restart");
    endtask

    task automatic dropStart(input string tag);
        start = 1'b0;
        tick();
        if (mState != S_HALT && mState != S_IDLE) mPc = 0;
        mState = S_IDLE;
        checkAll(tag);
    endtask

    // One instruction: expand it into its list of phases, drive each cycle, predict outcome.
    // abortAt: -1 none, -2 random phase, otherwise the phase index at which _start drops.
    task automatic runInsn(input int fw, input bit hlt, input bit mem, input bit rw,
                           input int mw, input bit bj, input bit rel,
                           input logic [PW-1:0] dst, input int abortAt);
        int seq[$];
        int ab, n, off;
        bit lastPhase;
        logic [IW-1:0] word;
        word = IW'($urandom);
        for (int k = 0; k <= fw; k++) seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        if (!hlt) begin
            seq.push_back(S_EXEC);
            if (mem) for (int k = 0; k <= mw; k++) seq.push_back(S_MEM);
            if (rw) seq.push_back(S_WB);
        end
        n  = seq.size();
        ab = (abortAt == -2) ? int'($urandom_range(0, n - 1)) : abortAt;
        halt = hlt; memAccess = mem; regWrite = rw;
        branchJump = bj; relative = rel; destBranchJump = dst; insnIn = word;
        for (int i = 0; i < n; i++) begin
            lastPhase = (i == n - 1) ? 1'b1 : (seq[i + 1] != seq[i]);
            start     = (i != ab);
            insnValid = (seq[i] == S_FETCH) ? lastPhase : 1'($urandom);
            memReady  = (seq[i] == S_MEM) ? lastPhase : 1'($urandom);
            tick();
            if (i == ab) begin
                mPc = 0;
                mState = S_IDLE;
                checkAll("abort");
                start = 1'b1;
                return;
            end
            mCyc = (mCyc == CMAX) ? CMAX : mCyc + 1;
            if (seq[i] == S_FETCH && lastPhase) mIr = word;
            if (i < n - 1) begin
                mState = seq[i + 1];
            end else if (hlt) begin
                mState = S_HALT;
            end else begin
                mInsn = (mInsn + 1) % (CMAX + 1);
                off   = (dst >= (1 << (PW - 1))) ? int'(dst) - (1 << PW) : int'(dst);
                if (!bj) mPc = (mPc + 1) % (1 << PW);
                else if (!rel) mPc = dst;
                else mPc = (mPc + off + (1 << PW)) % (1 << PW);
                mState = S_FETCH;
            end
            checkAll("step");
        end
    endtask

    task automatic randInsn(input bit allow);
        runInsn(int'($urandom % 3), allow && ($urandom % 100 < 2), 1'($urandom), 1'($urandom),
                int'($urandom % 3), ($urandom % 3 == 0), 1'($urandom), PW'($urandom),
                (allow && ($urandom % 100 < 3)) ? -2 : -1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; insnValid = 1'b0; halt = 1'b0; memAccess = 1'b0;
        regWrite = 1'b0; branchJump = 1'b0; relative = 1'b0; memReady = 1'b0;
        insnIn = '0; destBranchJump = '0;
        mState = S_IDLE; mPc = 0; mIr = 0; mInsn = 0; mCyc = 0;
        #12;
        checkAll("reset");
        reset = 1'b0;
        tick();
        checkAll("idle_hold");
        restart();

        // Three plain ALU ops with register write, then a halt
        for (int k = 0; k < 3; k++) runInsn(0, 0, 0, 1, 0, 0, 0, '0, -1);
        chk("alu_pc", 32'(pc), 32'd3);
        runInsn(0, 1, 0, 0, 0, 0, 0, '0, -1);
        chk("halt_insnCount", 32'(insnCount), 32'd3);
        for (int k = 0; k < 2; k++) begin
            insnValid = 1'($urandom); memReady = 1'($urandom);
            tick();
            checkAll("halt_hold");
        end
        dropStart("halt_exit");
        restart();

        // Load with three data-memory wait states
        runInsn(0, 0, 1, 1, 3, 0, 0, '0, -1);
        chk("load_pc", 32'(pc), 32'd1);

        // PC wrap with relative and absolute targets
        runInsn(0, 0, 0, 0, 0, 1, 0, 10'h3FE, -1);
        chk("jmp_abs_3fe", 32'(pc), 32'h3FE);
        runInsn(0, 0, 0, 0, 0, 1, 1, 10'h004, -1);
        chk("rel_wrap_fwd", 32'(pc), 32'h002);
        runInsn(0, 0, 0, 0, 0, 1, 1, 10'h3FD, -1);
        chk("rel_wrap_back", 32'(pc), 32'h3FF);
        runInsn(0, 0, 0, 0, 0, 1, 0, 10'h123, -1);
        chk("jmp_abs_123", 32'(pc), 32'h123);

        // Instruction memory stalls for five cycles
        runInsn(5, 0, 0, 1, 0, 0, 0, '0, -1);

        // Abort in EXECUTE after seven retirements, then relaunch
        dropStart("abort_fetch");
        restart();
        for (int k = 0; k < 7; k++)
            runInsn(int'($urandom % 2), 0, 1'($urandom), 1'($urandom), 0, 0, 0, '0, -1);
        runInsn(0, 0, 0, 1, 0, 0, 0, '0, 2);
        chk("abort_insnCount", 32'(insnCount), 32'd7);
        restart();

        // Long stream: retire counter wraps, cycle counter saturates
        for (int k = 0; k < 270; k++) randInsn(1'b0);
        chk("insn_wrap", 32'(insnCount), 32'(270 % (CMAX + 1)));
        chk("cycle_sat", 32'(cycleCount), 32'(CMAX));

        // Mixed stream with random halts and aborts
        for (int k = 0; k < 150; k++) begin
            randInsn(1'b1);
            if (mState == S_HALT) begin
                for (int h = 0; h < int'($urandom % 3); h++) begin
                    insnValid = 1'($urandom);
                    tick();
                    checkAll("rand_halt_hold");
                end
                dropStart("rand_halt_exit");
            end
            if (mState == S_IDLE) restart();
        end

        // Asynchronous reset while waiting in MEMORY at pc 0x05
        runInsn(0, 0, 0, 0, 0, 1, 0, 10'h005, -1);
        insnValid = 1'b1; memAccess = 1'b1; regWrite = 1'b0; halt = 1'b0;
        memReady = 1'b0; start = 1'b1;
        tick(); tick(); tick();
        chk("mem_wait_state", 32'(state), 32'd4);
        chk("mem_wait_en", 32'(memEnable), 32'd1);
        chk("mem_wait_pc", 32'(pc), 32'h005);
        #2 reset = 1'b1;
        #1;
        mState = S_IDLE; mPc = 0; mIr = 0; mInsn = 0; mCyc = 0;
        checkAll("async_reset");
        #2 reset = 1'b0;
        start = 1'b0;
        tick();
        checkAll("post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
